// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Shared constants and the state encoding used by the UART receiver and
// by the optional echo transmitter in uart_word_loader.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_core.sv
// Module: uart_rx_core
// 8N1 UART receiver. The raw line passes a 2-flop synchroniser, then an
// IDLE/START/DATA/STOP FSM samples it mid-bit.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   serial_in  - RX line, idle high, asynchronous to clk
//   byte_ok    - one-cycle strobe: stop bit sampled high, byte_data is good
//   byte_err   - one-cycle strobe: stop bit sampled low (framing error)
//   byte_data  - received byte (valid while byte_ok is high)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic       byte_ok,
  output logic       byte_err,
  output logic [7:0] byte_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic        sync1_q, sync2_q, prev_q;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    byte_ok  = 1'b0;
    byte_err = 1'b0;
    case (state_q)
      IDLE: begin
        // Start on a falling edge, not a low level, so a line still held low
        // after a framing error does not retrigger immediately.
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? IDLE : DATA;  // high at mid start bit = glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};  // LSB arrives first
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          byte_ok  = sync2_q;
          byte_err = !sync2_q;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shreg_q;

endmodule : uart_rx_core

// File: rtl/uart_word_loader.sv
// Module: uart_word_loader
// Receives 8N1 UART bytes, packs them little-endian into DATA_WIDTH words and
// writes each completed word to a RAM write port at an auto-incrementing address.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   serial_in           - UART RX line
//   set_addr/start_addr - load write address and discard any partial word
//   wr_en/wr_addr/wr_data - RAM write port (wr_addr/wr_data hold between writes)
//   last_byte/byte_valid  - most recent good byte and its one-cycle strobe
//   frame_err/err_clr     - sticky framing-error flag and its clear
//   serial_out          - UART TX line
// Build option: define UART_ECHO_EN to retransmit each good byte on serial_out;
// otherwise serial_out is tied high.
module uart_word_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  set_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [7:0]            last_byte,
  output logic                  byte_valid,
  output logic                  frame_err,
  input  logic                  err_clr,
  output logic                  serial_out
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

  logic       rx_ok, rx_err;
  logic [7:0] rx_data;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .byte_ok   (rx_ok),
    .byte_err  (rx_err),
    .byte_data (rx_data)
  );

  logic [IDXW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, word_asm;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [7:0]            last_byte_q, last_byte_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_byte_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_byte_q  <= last_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    word_asm = word_q;
    word_asm[int'(idx_q) * 8 +: 8] = rx_data;

    idx_d        = idx_q;
    addr_d       = addr_q;
    word_d       = word_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_byte_d  = last_byte_q;
    byte_valid_d = 1'b0;
    // A new error wins over a simultaneous clear.
    frame_err_d  = rx_err ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);

    if (rx_ok) begin
      byte_valid_d = 1'b1;
      last_byte_d  = rx_data;
      word_d       = word_asm;
      if (idx_q == LAST_IDX) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = word_asm;
        addr_d    = addr_q + 1'b1;  // natural wrap at 2^ADDR_WIDTH
        idx_d     = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Applied last: a word completing this cycle has already been captured
    // at the old address above, and start_addr overrides the increment.
    if (set_addr) begin
      addr_d = start_addr;
      idx_d  = '0;
      word_d = '0;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_byte  = last_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

`ifdef UART_ECHO_EN
  localparam int TCW = $clog2(CLKS_PER_BIT);
  localparam logic [TCW-1:0] TX_BIT_END  = TCW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     TX_LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e    tx_state_q, tx_state_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shreg_q, tx_shreg_d;
  logic           tx_out_q, tx_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_out_q   <= tx_out_d;
    end
  end

  // tx_out_q is the line itself; each branch sets the level for the next bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_out_d   = tx_out_q;
    if (tx_state_q != IDLE) tx_cnt_d = tx_cnt_q + 1'b1;
    case (tx_state_q)
      IDLE: begin
        // Bytes arriving while busy are simply not echoed.
        if (byte_valid_q) begin
          tx_state_d = START;
          tx_shreg_d = last_byte_q;
          tx_cnt_d   = '0;
          tx_out_d   = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shreg_q[0];
          tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
        end
      end
      DATA: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == TX_LAST_BIT) begin
            tx_state_d = STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_out_d   = tx_shreg_q[0];
            tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_state_d = IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  assign serial_out = tx_out_q;
`else
  assign serial_out = 1'b1;
`endif

endmodule : uart_word_loader
